// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG bit pool.
// Contents: von Neumann extractor state enum, default parameter values,
//           and a helper giving the width of a 0..n counter.
package trng_pkg;

    typedef enum logic {
        VN_EMPTY = 1'b0,
        VN_HALF  = 1'b1
    } vn_state_t;

    localparam int unsigned POOL_DEPTH_DEF  = 32;
    localparam int unsigned RCT_CUTOFF_DEF  = 16;
    localparam int unsigned READY_LEVEL_DEF = 8;

    // Bits needed to hold any value in 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/trng_vn_extractor.sv
// Von Neumann debiasing extractor: pairs raw samples, emits the first bit of
// each unequal pair, discards equal pairs. Pairs never overlap.
// Ports:
//   clk, reset      clock, async active-high reset
//   raw_bit         raw sample
//   raw_valid       raw_bit is a new sample this cycle
//   clear           restart pairing (returns to EMPTY, drops any half-pair)
//   vn_bit          debiased bit (valid with vn_valid)
//   vn_valid        combinational strobe: vn_bit is emitted this cycle
module trng_vn_extractor
    import trng_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic raw_bit,
    input  logic raw_valid,
    input  logic clear,
    output logic vn_bit,
    output logic vn_valid
);

    vn_state_t state;
    vn_state_t state_n;
    logic      first_bit;
    logic      first_bit_n;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= VN_EMPTY;
            first_bit <= 1'b0;
        end else begin
            state     <= state_n;
            first_bit <= first_bit_n;
        end
    end

    // Pairing next-state and emit strobe
    always_comb begin
        state_n     = state;
        first_bit_n = first_bit;
        vn_valid    = 1'b0;
        vn_bit      = first_bit;
        if (clear) begin
            state_n     = VN_EMPTY;
            first_bit_n = 1'b0;
        end else if (raw_valid) begin
            case (state)
                VN_EMPTY: begin
                    state_n     = VN_HALF;
                    first_bit_n = raw_bit;
                end
                VN_HALF: begin
                    state_n  = VN_EMPTY;
                    vn_valid = (raw_bit != first_bit);
                end
                default: state_n = VN_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/trng_bitpool.sv
// TRNG bit pool: repetition-count health test, von Neumann debiasing and a
// FIFO pool of good bits handed out one per cycle on trng_req.
// Ports:
//   clk, reset    clock, async active-high reset
//   raw_bit       synchronised raw noise sample
//   raw_valid     raw_bit is a new sample this cycle
//   trng_req      consumer pops the head bit on this edge
//   trng_bit      head of the pool (combinational), 0 when empty
//   pool_count    number of bits held
//   pool_ready    pool_count >= READY_LEVEL
//   health_fail   sticky repetition-count failure (pool flushed, pushes off)
//   underflow     sticky pop-while-empty
//   clear_flags   clears both flags, restarts extractor and RCT
module trng_bitpool
    import trng_pkg::*;
#(
    parameter int unsigned POOL_DEPTH  = POOL_DEPTH_DEF,
    parameter int unsigned RCT_CUTOFF  = RCT_CUTOFF_DEF,
    parameter int unsigned READY_LEVEL = READY_LEVEL_DEF
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                raw_bit,
    input  logic                                raw_valid,
    input  logic                                trng_req,
    output logic                                trng_bit,
    output logic [cnt_width(POOL_DEPTH)-1:0]    pool_count,
    output logic                                pool_ready,
    output logic                                health_fail,
    output logic                                underflow,
    input  logic                                clear_flags
);

    localparam int unsigned CW = cnt_width(POOL_DEPTH);
    localparam int unsigned RW = cnt_width(RCT_CUTOFF);

    logic [POOL_DEPTH-1:0] pool_q;
    logic [POOL_DEPTH-1:0] pool_n;
    logic [CW-1:0]         count_n;
    logic [CW-1:0]         wr_idx;
    logic                  ready_n;
    logic                  pop;
    logic                  push;
    logic                  full;

    logic [RW-1:0]         rct_cnt;
    logic [RW-1:0]         rct_cnt_n;
    logic                  rct_last;
    logic                  rct_last_n;
    logic                  rct_have;
    logic                  rct_have_n;
    logic                  hf_set;
    logic                  uf_set;

    logic                  vn_bit;
    logic                  vn_valid;

    // Extractor is frozen while the health test has failed
    trng_vn_extractor u_vn (
        .clk      (clk),
        .reset    (reset),
        .raw_bit  (raw_bit),
        .raw_valid(raw_valid && !health_fail),
        .clear    (clear_flags),
        .vn_bit   (vn_bit),
        .vn_valid (vn_valid)
    );

    assign trng_bit = (pool_count != '0) ? pool_q[0] : 1'b0;

    // Repetition-count test; a clear restarts it and masks any flag set
    always_comb begin
        rct_cnt_n  = rct_cnt;
        rct_last_n = rct_last;
        rct_have_n = rct_have;
        hf_set     = 1'b0;
        if (clear_flags) begin
            rct_cnt_n  = '0;
            rct_last_n = 1'b0;
            rct_have_n = 1'b0;
        end else if (raw_valid) begin
            if (rct_have && (raw_bit == rct_last)) begin
                if (rct_cnt != RW'(RCT_CUTOFF)) begin
                    rct_cnt_n = rct_cnt + RW'(1);
                end
            end else begin
                rct_cnt_n  = RW'(1);
                rct_last_n = raw_bit;
                rct_have_n = 1'b1;
            end
            hf_set = (rct_cnt_n == RW'(RCT_CUTOFF));
        end
        uf_set = trng_req && (pool_count == '0) && !clear_flags;
    end

    // Pool shift register: head at bit 0, a pop shifts toward the head and a
    // simultaneous push lands one slot lower to fill the vacated tail
    always_comb begin
        pop    = trng_req && (pool_count != '0);
        full   = (pool_count == CW'(POOL_DEPTH));
        push   = vn_valid && !health_fail && (!full || pop);
        wr_idx = pop ? (pool_count - CW'(1)) : pool_count;
        pool_n = pop ? (pool_q >> 1) : pool_q;
        for (int unsigned i = 0; i < POOL_DEPTH; i++) begin
            if (push && (CW'(i) == wr_idx)) begin
                pool_n[i] = vn_bit;
            end
        end
        count_n = pool_count;
        if (push && !pop) begin
            count_n = pool_count + CW'(1);
        end else if (pop && !push) begin
            count_n = pool_count - CW'(1);
        end
        if (hf_set) begin
            pool_n  = '0;
            count_n = '0;
        end
        ready_n = (count_n >= CW'(READY_LEVEL));
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pool_q      <= '0;
            pool_count  <= '0;
            pool_ready  <= 1'b0;
            rct_cnt     <= '0;
            rct_last    <= 1'b0;
            rct_have    <= 1'b0;
            health_fail <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            pool_q      <= pool_n;
            pool_count  <= count_n;
            pool_ready  <= ready_n;
            rct_cnt     <= rct_cnt_n;
            rct_last    <= rct_last_n;
            rct_have    <= rct_have_n;
            health_fail <= clear_flags ? 1'b0 : (health_fail || hf_set);
            underflow   <= clear_flags ? 1'b0 : (underflow || uf_set);
        end
    end

endmodule
